data_mem_port: RTL
==================

# data_mem_port

Data-side memory port for the Titan core: accepts one load/store request at a time from the MEM stage and runs it as a single Wishbone classic cycle on the data bus. It produces byte-lane selects, replicated store data, and aligned, sign- or zero-extended load data. It stalls the pipeline while the request is outstanding and reports misalignment, bus error and timeout. It is the data-bus counterpart of the instruction fetch port and connects to the same bus fabric.

## Interface
- TIMEOUT, 10: number of D_BUS cycles without `dack_i`/`derr_i` before the port aborts the request.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  request present; held stable by the MEM stage until the completion cycle.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- mem_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-justified.
- mem_rdata  out  32  load result; valid in the completion cycle and held until the next load.
- mem_done  out  1  one-cycle pulse when the request completes without error.
- mem_err  out  1  one-cycle pulse on `derr_i`, timeout, or illegal size.
- mem_misalign  out  1  one-cycle pulse when the address is misaligned; no bus cycle is issued.
- mem_stall  out  1  combinational: `mem_valid && state != D_DONE`.
- ddat_i  in  32  bus read data.
- dack_i  in  1  bus acknowledge.
- derr_i  in  1  bus error.
- daddr_o  out  32  word address, `{mem_addr[31:2],2'b00}`.
- ddat_o  out  32  store data, replicated across lanes.
- dsel_o  out  4  byte-lane selects.
- dcyc_o  out  1  Wishbone cycle.
- dstb_o  out  1  Wishbone strobe.
- dwe_o  out  1  Wishbone write enable.

## Operation
- States:
  - D_IDLE: no request in progress.
  - D_BUS: `dcyc_o` and `dstb_o` asserted, waiting for the slave.
  - D_DONE: exactly one cycle, in which the completion flag pulses.
- D_IDLE with `mem_valid`:
  - If the size is illegal, go to D_DONE with `mem_err` set.
  - Misalignment is defined as: half with `addr[0]=1`, or word with `addr[1:0]≠0`. If misaligned, go to D_DONE with `mem_misalign` set.
  - Otherwise, register `daddr_o`, `ddat_o`, `dsel_o` and `dwe_o`, set `dcyc_o=dstb_o=1`, clear the timeout counter, and go to D_BUS.
- Select lanes:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- D_BUS, evaluated in priority order:
  1. `derr_i`: set `mem_err`.
  2. `dack_i`: on a load, latch the extracted lane of `ddat_i` into `mem_rdata`, extended per `mem_unsigned`; set `mem_done`.
  3. Counter equals TIMEOUT−1: set `mem_err`.
  4. Otherwise, increment the counter.
- Outcomes 1–3 drop `dcyc_o` and `dstb_o` and go to D_DONE.
- Load extraction: the byte lane is `addr[1:0]`; the half lane is `addr[1]`.
- D_DONE: clear the completion flags, then go to D_IDLE. A new request is sampled in D_IDLE on the following cycle.
- `dack_i` and `derr_i` are ignored outside D_BUS.
- A store or an error leaves `mem_rdata` unchanged.

## Timing
- Reset values: every output register is 0, including `daddr_o`, `ddat_o`, `dsel_o`, `dcyc_o`, `dstb_o`, `dwe_o`, `mem_rdata`, `mem_done`, `mem_err` and `mem_misalign`. The state is D_IDLE.
- Reset mid-transaction drops `dcyc_o`/`dstb_o` at that edge; no completion pulse is generated.
- Zero-wait-state slave: request sampled at edge E0, `dcyc_o`/`dstb_o` high after E0, ack sampled at E1, `mem_done` high in the E1–E2 cycle, D_IDLE after E2. Each wait state adds one cycle.
- Misalign and illegal-size requests report after one cycle and never assert `dcyc_o`.
- Timeout: `dcyc_o` is high for exactly TIMEOUT cycles, then `mem_err` pulses.
- `dstb_o` always equals `dcyc_o`; there are no pipelined or burst cycles.
- The request inputs are sampled only in D_IDLE; changes during D_BUS are ignored.

## Structure
- Shared package `titan_mem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state encoding `D_IDLE`, `D_BUS`, `D_DONE`.
- One combinational sub-module, `load_align` (inputs `ddat_i`, `addr[1:0]`, `size`, `unsigned`; output the extended result), reused later by any cache refill path.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- Word load, addr `0x100`, slave returns `0xDEADBEEF` with zero waits -> `dsel_o=1111`, `daddr_o=0x100`, `mem_done` pulses at E1–E2, `mem_rdata=0xDEADBEEF`.
- Byte load, addr `0x103`, `ddat_i=0x80000000`:
  - signed -> `dsel_o=1000`, `mem_rdata=0xFFFFFF80`;
  - unsigned -> `mem_rdata=0x00000080`.
- Half store, addr `0x202`, `wdata=0x1234ABCD`, 3 wait states -> `ddat_o=0xABCDABCD`, `dsel_o=1100`, `dwe_o=1`, `mem_stall` high for 4 cycles, then `mem_done`.
- Word load at addr `0x101` -> `mem_misalign` pulses one cycle after the request, `dcyc_o` stays 0; size `11` -> `mem_err`, no bus cycle.
- Slave never responds -> `dcyc_o` high for 10 cycles, then `mem_err`. Separately, `dack_i` and `derr_i` together -> `mem_err` only, `mem_rdata` unchanged.
- `rst` asserted during D_BUS with 2 wait states outstanding -> all outputs 0 at the next edge; a following request completes normally.

Source files
------------

// File: rtl/titan_mem_pkg.sv
// Shared definitions for the Titan data-side memory path: size codes, port state
// and the lane/alignment helpers used on the request side.
package titan_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_BUS  = 2'b01,
    D_DONE = 2'b10
  } dstate_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << lo;
      SZ_HALF: sel = 4'b0011 << lo;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Wishbone classic data bus between the data memory port (master) and the fabric (slave).
interface data_mem_port_if;
  logic [31:0] ddat_i;
  logic        dack_i;
  logic        derr_i;
  logic [31:0] daddr_o;
  logic [31:0] ddat_o;
  logic [3:0]  dsel_o;
  logic        dcyc_o;
  logic        dstb_o;
  logic        dwe_o;

  modport master (
    input  ddat_i, dack_i, derr_i,
    output daddr_o, ddat_o, dsel_o, dcyc_o, dstb_o, dwe_o
  );

  modport slave (
    output ddat_i, dack_i, derr_i,
    input  daddr_o, ddat_o, dsel_o, dcyc_o, dstb_o, dwe_o
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a bus word and sign- or zero-extends it.
module load_align
  import titan_mem_pkg::*;
(
  input  logic [31:0] i_ddat,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_ddat[7:0];
      2'd1:    w_byte = i_ddat[15:8];
      2'd2:    w_byte = i_ddat[23:16];
      default: w_byte = i_ddat[31:24];
    endcase
    w_half = i_addr[1] ? i_ddat[31:16] : i_ddat[15:0];
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_ddat;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Data-side memory port: runs one MEM-stage load/store as a single Wishbone classic
// cycle, with lane selection, load alignment, misalign/error/timeout reporting.
module data_mem_port
  import titan_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  output logic            mem_done,
  output logic            mem_err,
  output logic            mem_misalign,
  output logic            mem_stall,
  data_mem_port_if.master dbus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  dstate_e         r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic [31:0]     r_daddr, w_daddr_nxt;
  logic [31:0]     r_ddat, w_ddat_nxt;
  logic [3:0]      r_dsel, w_dsel_nxt;
  logic            r_dcyc, w_dcyc_nxt;
  logic            r_dwe, w_dwe_nxt;
  // Request attributes kept for load extraction, since live inputs are ignored in D_BUS.
  logic [1:0]      r_lane, w_lane_nxt;
  logic [1:0]      r_size, w_size_nxt;
  logic            r_unsigned, w_unsigned_nxt;

  logic            w_bad_size;
  logic            w_misalign_req;
  logic            w_cnt_last;
  logic [31:0]     w_load_data;

  assign w_bad_size     = (mem_size == 2'b11);
  assign w_misalign_req = is_misaligned(mem_size, mem_addr[1:0]);
  assign w_cnt_last     = (r_cnt == CntLast);

  load_align u_load_align (
    .i_ddat     (dbus.ddat_i),
    .i_addr     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= D_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      D_IDLE: begin
        if (mem_valid) w_state_nxt = (w_bad_size || w_misalign_req) ? D_DONE : D_BUS;
      end
      D_BUS: begin
        if (dbus.derr_i || dbus.dack_i || w_cnt_last) w_state_nxt = D_DONE;
      end
      D_DONE:  w_state_nxt = D_IDLE;
      default: w_state_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_rdata_nxt    = r_rdata;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_misalign_nxt = 1'b0;
    w_daddr_nxt    = r_daddr;
    w_ddat_nxt     = r_ddat;
    w_dsel_nxt     = r_dsel;
    w_dcyc_nxt     = r_dcyc;
    w_dwe_nxt      = r_dwe;
    w_lane_nxt     = r_lane;
    w_size_nxt     = r_size;
    w_unsigned_nxt = r_unsigned;
    case (r_state)
      D_IDLE: begin
        if (mem_valid) begin
          if (w_bad_size) begin
            w_err_nxt = 1'b1;
          end else if (w_misalign_req) begin
            w_misalign_nxt = 1'b1;
          end else begin
            w_daddr_nxt    = {mem_addr[31:2], 2'b00};
            w_ddat_nxt     = store_data(mem_size, mem_wdata);
            w_dsel_nxt     = lane_sel(mem_size, mem_addr[1:0]);
            w_dwe_nxt      = mem_we;
            w_dcyc_nxt     = 1'b1;
            w_cnt_nxt      = '0;
            w_lane_nxt     = mem_addr[1:0];
            w_size_nxt     = mem_size;
            w_unsigned_nxt = mem_unsigned;
          end
        end
      end
      D_BUS: begin
        if (dbus.derr_i) begin
          w_err_nxt  = 1'b1;
          w_dcyc_nxt = 1'b0;
        end else if (dbus.dack_i) begin
          if (!r_dwe) w_rdata_nxt = w_load_data;
          w_done_nxt = 1'b1;
          w_dcyc_nxt = 1'b0;
        end else if (w_cnt_last) begin
          w_err_nxt  = 1'b1;
          w_dcyc_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_daddr    <= '0;
      r_ddat     <= '0;
      r_dsel     <= '0;
      r_dcyc     <= 1'b0;
      r_dwe      <= 1'b0;
      r_lane     <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_rdata    <= w_rdata_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_misalign <= w_misalign_nxt;
      r_daddr    <= w_daddr_nxt;
      r_ddat     <= w_ddat_nxt;
      r_dsel     <= w_dsel_nxt;
      r_dcyc     <= w_dcyc_nxt;
      r_dwe      <= w_dwe_nxt;
      r_lane     <= w_lane_nxt;
      r_size     <= w_size_nxt;
      r_unsigned <= w_unsigned_nxt;
    end
  end

  assign mem_rdata    = r_rdata;
  assign mem_done     = r_done;
  assign mem_err      = r_err;
  assign mem_misalign = r_misalign;
  assign mem_stall    = mem_valid && (r_state != D_DONE);

  assign dbus.daddr_o = r_daddr;
  assign dbus.ddat_o  = r_ddat;
  assign dbus.dsel_o  = r_dsel;
  assign dbus.dcyc_o  = r_dcyc;
  assign dbus.dstb_o  = r_dcyc;
  assign dbus.dwe_o   = r_dwe;

endmodule
